// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: shifts a captured WIDTH-bit pattern out MSB-first on w,
// optionally looping, and flags every bit that extends a run of equal bits to four or more.
module serial_pattern_tx #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic             loop,
    output logic             w,
    output logic             valid,
    output logic             busy,
    output logic             done,
    output logic             expect_z
);

    localparam int unsigned    IW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0]  LAST_IDX = IW'(WIDTH - 1);
    localparam logic [2:0]     RUN_MAX  = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [2:0]       run_q, run_d;
    logic             w_q, w_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             expect_z_q, expect_z_d;

    logic [WIDTH-1:0] shifted;
    logic             next_bit;
    logic             last_bit;

    assign last_bit = (idx_q == LAST_IDX);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            idx_q      <= '0;
            run_q      <= '0;
            w_q        <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            expect_z_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            idx_q      <= idx_d;
            run_q      <= run_d;
            w_q        <= w_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            expect_z_q <= expect_z_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        idx_d   = idx_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SEND;
                    shreg_d = pattern;
                    idx_d   = '0;
                end
            end
            ST_SEND: begin
                if (last_bit) begin
                    idx_d = '0;
                    if (!loop) begin
                        state_d = ST_DONE;
                    end
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Outputs are registered, so they are computed from the state about to be entered:
    // the bit shown next cycle and its run length are resolved one edge early.
    always_comb begin
        shifted    = shreg_d << idx_d;
        next_bit   = shifted[WIDTH-1];
        run_d      = run_q;
        w_d        = 1'b0;
        valid_d    = 1'b0;
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_DONE);
        expect_z_d = 1'b0;
        if (state_d == ST_SEND) begin
            w_d     = next_bit;
            valid_d = 1'b1;
            if (state_q != ST_SEND) begin
                run_d = 3'd1;
            end else if (next_bit == w_q) begin
                run_d = (run_q >= RUN_MAX) ? RUN_MAX : run_q + 3'd1;
            end else begin
                run_d = 3'd1;
            end
            expect_z_d = (run_d == RUN_MAX);
        end else if (state_d == ST_DONE) begin
            run_d = '0;
        end
    end

    assign w        = w_q;
    assign valid    = valid_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign expect_z = expect_z_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: directed vector table with hand-derived waveforms plus
// randomized streams checked against a run-length model built from the pattern bits.
module tb_serial_pattern_tx;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [7:0] pattern;
    logic       loop;
    logic       w;
    logic       valid;
    logic       busy;
    logic       done;
    logic       expect_z;

    int total = 0;
    int bad   = 0;

    serial_pattern_tx #(.WIDTH(8)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .pattern  (pattern),
        .loop     (loop),
        .w        (w),
        .valid    (valid),
        .busy     (busy),
        .done     (done),
        .expect_z (expect_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  pat;
        int unsigned passes;
        bit          glitch;
        bit          abort_first;
        logic [31:0] exp_w;
        logic [31:0] exp_z;
        int          exp_done;
    } vec_t;

    vec_t tbl[5];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // {valid, w, expect_z, done, busy}
    function automatic logic [31:0] outs();
        return {27'd0, valid, w, expect_z, done, busy};
    endfunction

    // Start a stream in the current cycle and check every cycle up to the done pulse.
    task automatic send(input logic [7:0] pat, input int unsigned passes, input bit glitch,
                        input bit rnd_start, output logic [31:0] gw, output logic [31:0] gz,
                        output int dcyc);
        logic ebit[32];
        logic ez[32];
        int   run;
        int   n;
        logic [31:0] exp;
        n   = passes * 8;
        run = 0;
        for (int j = 0; j < n; j++) begin
            ebit[j] = pat[7 - (j % 8)];
            run = (j > 0 && ebit[j] == ebit[j-1]) ? run + 1 : 1;
            ez[j] = (run >= 4);
        end
        gw   = '0;
        gz   = '0;
        dcyc = -1;
        start   = 1'b1;
        pattern = pat;
        loop    = 1'($urandom);
        @(posedge clk); #1;
        for (int c = 1; c <= n + 1; c++) begin
            if (glitch)         start = (c == 3 || c == 9);
            else if (rnd_start) start = 1'($urandom);
            else                start = 1'b0;
            pattern = 8'($urandom);
            loop    = (c % 8 == 0) ? (c < n) : 1'($urandom);
            @(negedge clk);
            gw[c] = w;
            gz[c] = expect_z;
            if (done && dcyc < 0) dcyc = c;
            if (c <= n) exp = {27'd0, 1'b1, ebit[c-1], ez[c-1], 1'b0, 1'b1};
            else        exp = {27'd0, 5'b00011};
            check($sformatf("stream pat=%h cyc%0d", pat, c), outs(), exp);
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    // A zero-pattern stream cut by reset in cycle 5; leaves a full run that must not carry over.
    task automatic abort_stream();
        start   = 1'b1;
        pattern = 8'h00;
        loop    = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            if (c == 5) reset_n = 1'b0;
            @(negedge clk);
            check($sformatf("abort cyc%0d", c), outs(),
                  {27'd0, 1'b1, 1'b0, (c >= 4), 1'b0, 1'b1});
            @(posedge clk); #1;
        end
        reset_n = 1'b1;
        for (int c = 6; c <= 12; c++) begin
            @(negedge clk);
            check($sformatf("after abort cyc%0d", c), outs(), 32'd0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [31:0] gw, gz;
        int          dcyc;

        tbl[0] = '{8'hF0, 1, 1'b0, 1'b0, 32'h0000_001E, 32'h0000_0110, 9};
        tbl[1] = '{8'hAA, 1, 1'b0, 1'b0, 32'h0000_00AA, 32'h0000_0000, 9};
        tbl[2] = '{8'hC0, 2, 1'b0, 1'b0, 32'h0000_0606, 32'h0001_C1C0, 17};
        tbl[3] = '{8'hAA, 1, 1'b1, 1'b0, 32'h0000_00AA, 32'h0000_0000, 9};
        tbl[4] = '{8'h0F, 1, 1'b0, 1'b1, 32'h0000_01E0, 32'h0000_0110, 9};

        reset_n = 1'b0;
        start   = 1'b1;
        pattern = 8'hA5;
        loop    = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check($sformatf("reset cyc%0d", i), outs(), 32'd0);
            @(posedge clk); #1;
        end
        reset_n = 1'b1;
        start   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check($sformatf("post reset idle %0d", i), outs(), 32'd0);
            @(posedge clk); #1;
        end

        for (int i = 0; i < 5; i++) begin
            if (tbl[i].abort_first) abort_stream();
            send(tbl[i].pat, tbl[i].passes, tbl[i].glitch, 1'b0, gw, gz, dcyc);
            check($sformatf("vec%0d w", i), gw, tbl[i].exp_w);
            check($sformatf("vec%0d z", i), gz, tbl[i].exp_z);
            check($sformatf("vec%0d done", i), 32'(dcyc), 32'(tbl[i].exp_done));
        end

        for (int i = 0; i < 20; i++) begin
            int unsigned passes;
            passes = $urandom_range(1, 3);
            send(8'($urandom), passes, 1'b0, 1'b1, gw, gz, dcyc);
            check($sformatf("rand%0d done", i), 32'(dcyc), 32'(passes * 8 + 1));
            for (int k = $urandom_range(0, 2); k > 0; k--) begin
                @(negedge clk);
                check($sformatf("rand%0d gap", i), outs(), 32'd0);
                @(posedge clk); #1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
